// File: rtl/pattern_count_engine_if.sv
// Start/ack handshake plus data-memory port of the pattern count engine.
// The engine drives the memory side (master); the core/memory environment is the slave.
interface pattern_count_engine_if #(
  parameter int AW = 8
);
  logic          start;
  logic          ack;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data;

  modport master (
    input  start, mem_rd_data,
    output ack, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    output start, mem_rd_data,
    input  ack, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/pattern_count_engine.sv
// Scans an NBYTES byte string for a PAT_W-bit pattern and writes in-byte, per-byte and bitstream
// match counts to memory. Define PATCNT_MASK_EN to read a don't-care mask byte at RES_ADDR+3.
module pattern_count_engine #(
  parameter int PAT_W    = 5,
  parameter int NBYTES   = 32,
  parameter int AW       = 8,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33,
  parameter int CNT_W    = 8
) (
  input logic                    clk,
  input logic                    reset,
  pattern_count_engine_if.master bus
);
  localparam int               CW       = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [AW-1:0]    A_PAT    = AW'(PAT_ADDR);
  localparam logic [AW-1:0]    A_RES    = AW'(RES_ADDR);
  localparam logic [AW-1:0]    IDX_LAST = AW'(NBYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_PAT, LD_PAT,
`ifdef PATCNT_MASK_EN
    RD_MSK,
`endif
    SCAN, WR_B, WR_O, WR_S, DONE
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [CW-1:0]    r_carry;
  logic [AW-1:0]    r_idx;
  logic [CNT_W-1:0] r_ctb, r_cto, r_cts;
  logic             r_ack, r_wr_en;
  logic [AW-1:0]    r_addr;
  logic [7:0]       r_wr_data;

  logic [PAT_W-1:0] w_mask;
  logic [CW+7:0]    w_cat;
  logic [3:0]       w_in_hits, w_x_hits;
  logic [CNT_W-1:0] w_ctb_nxt, w_cto_nxt, w_cts_nxt;
  logic             w_last;

`ifdef PATCNT_MASK_EN
  logic [PAT_W-1:0] r_mask;
  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Earlier bytes sit in the upper bits, so w_cat reads MSB-first in bitstream order.
  assign w_cat  = {r_carry, bus.mem_rd_data};
  assign w_last = (r_idx == IDX_LAST);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_in_hits = '0;
    w_x_hits  = '0;
    for (int o = 0; o <= 8 - PAT_W; o++)
      if (((w_cat[o +: PAT_W] ^ r_pat) & ~w_mask) == '0) w_in_hits = w_in_hits + 4'd1;
    // Crossing windows straddle the carry/byte boundary; byte 0 has no predecessor.
    for (int o = 9 - PAT_W; o <= 7; o++)
      if (r_idx != '0 && ((w_cat[o +: PAT_W] ^ r_pat) & ~w_mask) == '0) w_x_hits = w_x_hits + 4'd1;
  end

  assign w_ctb_nxt = sat_add(r_ctb, w_in_hits);
  assign w_cto_nxt = sat_add(r_cto, {3'b000, (w_in_hits != 4'd0)});
  assign w_cts_nxt = sat_add(r_cts, w_in_hits + w_x_hits);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_carry   <= '0;
      r_idx     <= '0;
      r_ctb     <= '0;
      r_cto     <= '0;
      r_cts     <= '0;
      r_ack     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
`ifdef PATCNT_MASK_EN
      r_mask    <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE: if (bus.start) begin
          r_state <= RD_PAT;
          r_ack   <= 1'b0;
          r_addr  <= A_PAT;
        end
        RD_PAT: begin
          r_state <= LD_PAT;
`ifdef PATCNT_MASK_EN
          r_addr  <= A_RES + AW'(3);
`else
          r_addr  <= '0;
`endif
        end
        LD_PAT: begin
          r_pat   <= bus.mem_rd_data[7 -: PAT_W];
          r_ctb   <= '0;
          r_cto   <= '0;
          r_cts   <= '0;
          r_carry <= '0;
          r_idx   <= '0;
`ifdef PATCNT_MASK_EN
          r_state <= RD_MSK;
          r_addr  <= '0;
        end
        RD_MSK: begin
          r_mask  <= bus.mem_rd_data[7 -: PAT_W];
`endif
          r_state <= SCAN;
          r_addr  <= AW'(1);
        end
        SCAN: begin
          r_ctb   <= w_ctb_nxt;
          r_cto   <= w_cto_nxt;
          r_cts   <= w_cts_nxt;
          r_carry <= bus.mem_rd_data[CW-1:0];
          r_idx   <= r_idx + AW'(1);
          r_addr  <= r_addr + AW'(1);
          if (w_last) begin
            r_state   <= WR_B;
            r_addr    <= A_RES;
            r_wr_en   <= 1'b1;
            r_wr_data <= 8'(w_ctb_nxt);
          end
        end
        WR_B: begin
          r_state   <= WR_O;
          r_addr    <= A_RES + AW'(1);
          r_wr_en   <= 1'b1;
          r_wr_data <= 8'(r_cto);
        end
        WR_O: begin
          r_state   <= WR_S;
          r_addr    <= A_RES + AW'(2);
          r_wr_en   <= 1'b1;
          r_wr_data <= 8'(r_cts);
        end
        WR_S: begin
          r_state <= DONE;
          r_ack   <= 1'b1;
          r_addr  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_data = r_wr_data;
endmodule

// File: tb/tb_pattern_count_engine.sv
// Self-checking bench for pattern_count_engine: three instances (defaults, NBYTES=64, PAT_W=8),
// a behavioural memory per instance, table vectors, corner sequences and randomized runs.
module tb_pattern_count_engine;
  localparam int NI = 3;
  localparam int PW [NI] = '{5, 5, 8};
  localparam int NB [NI] = '{32, 64, 32};
  localparam int PA [NI] = '{32, 64, 32};
  localparam int RA [NI] = '{33, 65, 33};
`ifdef PATCNT_MASK_EN
  localparam int XLAT    = 7;
  localparam bit MASK_EN = 1'b1;
`else
  localparam int XLAT    = 6;
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct { int ctb; int cto; int cts; } counts_t;
  typedef struct { int g; logic [7:0] fill; logic [7:0] b0; logic [7:0] b1; logic [7:0] pat;
                   int ctb; int cto; int cts; } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem      [NI][256];
  logic       start_v  [NI];
  logic       ack_v    [NI];
  logic       wr_en_v  [NI];
  logic [7:0] addr_v   [NI];
  logic [7:0] wdata_v  [NI];
  int         wr_cnt_v [NI];
  int         bad_wr_v [NI];
  logic [7:0] cap_v    [NI][3];
  int         tests  = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    pattern_count_engine_if #(.AW(8)) bus ();
    int         wr_cnt = 0;
    int         bad_wr = 0;
    logic [7:0] cap [3];

    pattern_count_engine #(
      .PAT_W(PW[g]), .NBYTES(NB[g]), .AW(8), .PAT_ADDR(PA[g]), .RES_ADDR(RA[g]), .CNT_W(8)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus.master)
    );

    assign bus.start   = start_v[g];
    assign ack_v[g]    = bus.ack;
    assign wr_en_v[g]  = bus.mem_wr_en;
    assign addr_v[g]   = bus.mem_addr;
    assign wdata_v[g]  = bus.mem_wr_data;
    assign wr_cnt_v[g] = wr_cnt;
    assign bad_wr_v[g] = bad_wr;
    assign cap_v[g][0] = cap[0];
    assign cap_v[g][1] = cap[1];
    assign cap_v[g][2] = cap[2];

    always @(posedge clk) begin
      bus.mem_rd_data <= mem[g][bus.mem_addr];
      if (bus.mem_wr_en) begin
        wr_cnt <= wr_cnt + 1;
        if (bus.mem_addr >= 8'(RA[g]) && bus.mem_addr <= 8'(RA[g] + 2))
          cap[2'(bus.mem_addr - 8'(RA[g]))] <= bus.mem_wr_data;
        else
          bad_wr <= bad_wr + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: slide a window over the MSB-first bitstream; a window is in-byte when it
  // starts and ends in the same byte. Counts only grow, so saturating once at the end is exact.
  function automatic counts_t model(input int g);
    counts_t    r;
    int         w;
    logic [7:0] pb, mb;
    bit         hit_byte [256];
    bit         ok;
    w  = PW[g];
    pb = mem[g][PA[g]];
    mb = MASK_EN ? mem[g][RA[g] + 3] : 8'h00;
    r  = '{0, 0, 0};
    for (int b = 0; b < 256; b++) hit_byte[b] = 1'b0;
    for (int s = 0; s + w <= 8 * NB[g]; s++) begin
      ok = 1'b1;
      for (int j = 0; j < w; j++) begin
        int i = s + j;
        if (!mb[7-j] && mem[g][i / 8][7 - (i % 8)] !== pb[7-j]) ok = 1'b0;
      end
      if (ok) begin
        r.cts++;
        if (s / 8 == (s + w - 1) / 8) begin
          r.ctb++;
          hit_byte[s / 8] = 1'b1;
        end
      end
    end
    for (int b = 0; b < NB[g]; b++) if (hit_byte[b]) r.cto++;
    if (r.ctb > 255) r.ctb = 255;
    if (r.cto > 255) r.cto = 255;
    if (r.cts > 255) r.cts = 255;
    return r;
  endfunction

  task automatic fill(input int g, input logic [7:0] f, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] pat, input logic [7:0] msk);
    for (int i = 0; i < NB[g]; i++) mem[g][i] = f;
    mem[g][0]         = b0;
    mem[g][1]         = b1;
    mem[g][PA[g]]     = pat;
    mem[g][RA[g] + 3] = msk;
  endtask

  task automatic check_counts(input string tag, input counts_t got, input counts_t exp);
    check({tag, "/ctb"}, got.ctb, exp.ctb);
    check({tag, "/cto"}, got.cto, exp.cto);
    check({tag, "/cts"}, got.cts, exp.cts);
  endtask

  // One start pulse; checks ack falls in cycle 1, ack latency, and exactly three in-range writes.
  task automatic run_op(input int g, input string tag, output counts_t got);
    int n, w0, b0;
    @(negedge clk);
    w0 = wr_cnt_v[g];
    b0 = bad_wr_v[g];
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    n = 1;
    check({tag, "/ack_c1"}, ack_v[g], 0);
    while (!ack_v[g] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ack_cycle"}, n, NB[g] + XLAT);
    check({tag, "/writes"}, wr_cnt_v[g] - w0, 3);
    check({tag, "/bad_writes"}, bad_wr_v[g] - b0, 0);
    got = '{int'(cap_v[g][0]), int'(cap_v[g][1]), int'(cap_v[g][2])};
  endtask

  initial begin
    vec_t    tbl [8];
    counts_t got, exp;
    int      n, w0, ack_seen;

    tbl[0] = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 252};
    tbl[1] = '{0, 8'h55, 8'h55, 8'h55, 8'hA8,  64, 32, 126};
    tbl[2] = '{0, 8'h00, 8'h03, 8'h80, 8'h38,   0,  0,   1};
    tbl[3] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 255, 64, 255};
    tbl[4] = '{2, 8'hFF, 8'hFF, 8'hFF, 8'hFF,  32, 32, 249};
    tbl[5] = '{2, 8'h00, 8'hA5, 8'h00, 8'hA5,   1,  1,   1};
    tbl[6] = '{0, 8'h00, 8'h00, 8'h00, 8'hF8,   0,  0,   0};
    tbl[7] = '{0, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 128, 32, 252};

    for (int g = 0; g < NI; g++) begin
      start_v[g] = 1'b0;
      for (int a = 0; a < 256; a++) mem[g][a] = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst%0d/ack", g), ack_v[g], 0);
      check($sformatf("rst%0d/wr_en", g), wr_en_v[g], 0);
      check($sformatf("rst%0d/addr", g), addr_v[g], 0);
      check($sformatf("rst%0d/wdata", g), wdata_v[g], 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].g, tbl[i].fill, tbl[i].b0, tbl[i].b1, tbl[i].pat, 8'h00);
      run_op(tbl[i].g, $sformatf("vec%0d", i), got);
      check_counts($sformatf("vec%0d", i), got, '{tbl[i].ctb, tbl[i].cto, tbl[i].cts});
    end

    // ack holds in DONE while start stays low.
    repeat (10) @(negedge clk);
    check("done_hold/ack", ack_v[0], 1);

    // Reset in SCAN cycle 10: no ack, no writes; the next operation runs cleanly.
    fill(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst/ack", ack_v[0], 0);
    check("midrst/wr_en", wr_en_v[0], 0);
    check("midrst/addr", addr_v[0], 0);
    w0 = wr_cnt_v[0];
    ack_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack_v[0]) ack_seen++;
    end
    check("midrst/no_ack", ack_seen, 0);
    check("midrst/no_writes", wr_cnt_v[0] - w0, 0);
    run_op(0, "after_rst", got);
    check_counts("after_rst", got, '{128, 32, 252});

    // A start pulse in the middle of SCAN must not restart or duplicate the operation.
    fill(0, 8'h55, 8'h55, 8'h55, 8'hA8, 8'h00);
    @(negedge clk);
    w0 = wr_cnt_v[0];
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 1;
    while (!ack_v[0] && n < 500) begin
      @(negedge clk);
      n++;
      if (n == 15) start_v[0] = 1'b1;
      if (n == 16) start_v[0] = 1'b0;
    end
    check("repulse/ack_cycle", n, NB[0] + XLAT);
    repeat (10) @(negedge clk);
    check("repulse/writes", wr_cnt_v[0] - w0, 3);
    check("repulse/ack_hold", ack_v[0], 1);
    check_counts("repulse", '{int'(cap_v[0][0]), int'(cap_v[0][1]), int'(cap_v[0][2])},
                 '{64, 32, 126});

`ifdef PATCNT_MASK_EN
    fill(0, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'hF8);
    run_op(0, "mask_all", got);
    check_counts("mask_all", got, '{128, 32, 252});
`endif

    for (int it = 0; it < 24; it++) begin
      int g;
      g = (it % 4 == 3) ? 2 : 0;
      for (int b = 0; b < NB[g]; b++) begin
        case ($urandom_range(0, 3))
          0:       mem[g][b] = 8'h00;
          1:       mem[g][b] = 8'hFF;
          2:       mem[g][b] = (b % 2 == 0) ? 8'h55 : 8'hAA;
          default: mem[g][b] = 8'($urandom);
        endcase
      end
      mem[g][PA[g]]     = 8'($urandom);
      mem[g][RA[g] + 3] = MASK_EN ? 8'($urandom & $urandom) : 8'h00;
      exp = model(g);
      run_op(g, $sformatf("rnd%0d", it), got);
      check_counts($sformatf("rnd%0d", it), got, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
- Hardware successor to the program-3 software pattern search.
- Scans an NBYTES-long byte string in data memory for a PAT_W-bit pattern.
- Computes three counts:
  - ctb: in-byte matches.
  - cto: bytes containing at least one match.
  - cts: matches in the continuous bitstream, including windows that cross byte boundaries.
- Writes the three counts back to data memory. Sits beside the core on the data-memory port and uses the start/ack handshake.

Parameters:
- PAT_W, 5, pattern width in bits, legal 1..8.
- NBYTES, 32, string length in bytes, string at addresses 0..NBYTES-1, legal 2..2^AW-4.
- AW, 8, memory address width.
- PAT_ADDR, 32, address of the pattern byte; pattern = byte[7:8-PAT_W] (MSB-aligned).
- RES_ADDR, 33, results base address: ctb at RES_ADDR, cto at +1, cts at +2.
- CNT_W, 8, counter width; all counts saturate at 2^CNT_W-1; results are written as the low 8 bits.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, level sampled in IDLE or DONE; begins an operation.
- ack, output, 1, high in DONE; operation complete.
- mem_addr, output, AW, memory address.
- mem_wr_en, output, 1, write strobe, one cycle per result.
- mem_wr_data, output, 8, write data.
- mem_rd_data, input, 8, read data; registered memory, valid the cycle after mem_addr is presented.

Behaviour:
- Reset (synchronous, priority over everything, including mid-operation):
  - State=IDLE; ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - Counters, pattern register and carry register cleared.
  - No write may occur in the cycle after reset is sampled.
- State sequence, with cycle 0 = the cycle start is sampled high:
  - IDLE -> RD_PAT (cycle 1): mem_addr=PAT_ADDR.
  - LD_PAT (cycle 2): latch pattern; mem_addr=0; clear counters and carry.
  - SCAN (cycles 3..NBYTES+2): process byte k=cycle-3 from mem_rd_data; mem_addr=k+1.
  - WR_B, WR_O, WR_S (cycles NBYTES+3..+5): mem_wr_en=1, addresses RES_ADDR, +1, +2.
  - DONE (cycle NBYTES+6, 38 at defaults): ack=1.
- DONE handling:
  - ack stays high until start is sampled high again; that sample re-enters RD_PAT and ack falls the next cycle.
  - start is ignored in all states other than IDLE and DONE.
- Per-byte arithmetic:
  - In-byte windows are byte[o+PAT_W-1:o] for o=0..8-PAT_W.
  - ctb += number of equal windows; cto += 1 if any window matches.
  - Crossing windows use the concatenation {carry[PAT_W-2:0], byte}; carry = previous byte's low PAT_W-1 bits.
  - A crossing window spans bits from both bytes. There are PAT_W-1 such windows, counted only for k>0.
  - cts += in-byte + crossing matches.
  - Bitstream order is byte 0 MSB first; total windows = 8*NBYTES-PAT_W+1.
- Boundary cases:
  - PAT_W=1: no crossing windows, so cts==ctb.
  - PAT_W=8: one window per byte, so ctb==cto.
  - Saturation is checked every add; a counter never wraps.
- mem_wr_en is never asserted outside the WR_* states.

Optional Feature:
- PATCNT_MASK_EN defined:
  - Adds state RD_MSK after LD_PAT; reads the mask byte at RES_ADDR+3, MSB-aligned like the pattern.
  - Mask bit=1 means don't-care in every compare.
  - Latency grows by one cycle: ack at NBYTES+7.
- Undefined: exact compare, no mask read, latency as above.

Test Plan:
- Defaults, all bytes 0x00, pattern 0x00 -> ctb=128, cto=32, cts=252; ack first high at cycle 38; writes only to 33/34/35.
- Defaults, all bytes 0x55, pattern 0xA8 (10101) -> ctb=64, cto=32, cts=126.
- Defaults, byte0=0x03, byte1=0x80, rest 0x00, pattern 0x38 (00111) -> ctb=0, cto=0, cts=1 (crossing window only).
- NBYTES=64, all 0x00, pattern 0x00 -> ctb=255 (saturated from 256), cto=64, cts=255 (saturated from 508).
- Reset asserted in SCAN cycle 10 -> ack=0 and no mem_wr_en; start pulsed again -> results match scenario 1.
- start re-pulsed during SCAN -> ignored, single result set. PAT_W=8 instance, all 0xFF, pattern 0xFF -> ctb=cto=32, cts=249. With PATCNT_MASK_EN, mask 0xF8 -> ctb=128, ack at cycle 39.
